// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit: FSM states, parameter
// defaults, counter widths and the hard-wired zero register specifier.
package hazard_pkg;

  localparam int unsigned MUL_LAT_DEF   = 4;   // EX multiply latency (2..16)
  localparam int unsigned DRAIN_CYC_DEF = 3;   // EX/MEM/WB drain cycles (1..15)
  localparam int unsigned REG_W_DEF     = 4;   // register specifier width
  localparam int unsigned CNT_W         = 4;   // shared MUL_WAIT/DRAIN down-counter
  localparam int unsigned STALL_W       = 16;  // stall statistics counter
  localparam int unsigned ZERO_REG      = 0;   // register that never hazards

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MUL_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALTED   = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_cmp.sv
// Load-use detector: a load in EX writes a register the ID instruction reads.
// Ports: EX valid/load/destination, ID valid/sources/source-use flags in;
//        load_use_c out (combinational).
module hazard_cmp
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rs_i,
  input  logic             id_uses_rt_i,
  output logic             load_use_c
);

  logic rd_nonzero;
  logic rs_hit;
  logic rt_hit;

  // Register 0 is constant, so a load targeting it can never hazard.
  assign rd_nonzero = (ex_rd_i != REG_W'(ZERO_REG));
  assign rs_hit     = id_uses_rs_i & (id_rs_i == ex_rd_i);
  assign rt_hit     = id_uses_rt_i & (id_rt_i == ex_rd_i);
  assign load_use_c = ex_valid_i & ex_mem_read_i & rd_nonzero & id_valid_i
                    & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: branch flush, multiply stall, load-use stall and
// HALT drain sequencing, plus a saturating count of stalled fetch cycles.
// Ports: clk, rst (async active-low); ID/EX hazard inputs; control outputs
//        stop_pc, halt, ifid_hold/flush, idex_bubble/hold, pipe_done
//        (combinational from state, counter and inputs); stall_cnt (registered).
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MUL_LAT   = MUL_LAT_DEF,
  parameter int unsigned DRAIN_CYC = DRAIN_CYC_DEF,
  parameter int unsigned REG_W     = REG_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [REG_W-1:0]   id_rs,
  input  logic [REG_W-1:0]   id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic               id_is_halt,
  input  logic               ex_valid,
  input  logic               ex_mem_read,
  input  logic               ex_mul_start,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               ex_branch_taken,
  output logic               stop_pc,
  output logic               halt,
  output logic               ifid_hold,
  output logic               ifid_flush,
  output logic               idex_bubble,
  output logic               idex_hold,
  output logic               pipe_done,
  output logic [STALL_W-1:0] stall_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               load_use;
  logic               id_halt;

  assign id_halt = id_valid & id_is_halt;

  hazard_cmp #(
    .REG_W (REG_W)
  ) u_cmp (
    .ex_valid_i    (ex_valid),
    .ex_mem_read_i (ex_mem_read),
    .ex_rd_i       (ex_rd),
    .id_valid_i    (id_valid),
    .id_rs_i       (id_rs),
    .id_rt_i       (id_rt),
    .id_uses_rs_i  (id_uses_rs),
    .id_uses_rt_i  (id_uses_rt),
    .load_use_c    (load_use)
  );

  // State, shared down-counter and stall statistics.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Next state and counter load/decrement.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RUN: begin
        // A taken branch squashes whatever sits in ID, including HALT.
        if (ex_branch_taken) begin
          state_d = ST_RUN;
        end else if (ex_mul_start) begin
          // The first stall cycle is spent here in RUN.
          cnt_d   = CNT_W'(MUL_LAT - 2);
          state_d = ST_MUL_WAIT;
        end else if (id_halt) begin
          cnt_d   = CNT_W'(DRAIN_CYC - 1);
          state_d = ST_DRAIN;
        end
      end
      ST_MUL_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else             state_d = ST_HALTED;
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_RUN;
    endcase
  end

  // Saturating count of cycles with the fetch address held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stop_pc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  // Output decode; gated by rst because RUN outputs follow the inputs directly.
  always_comb begin
    stop_pc     = 1'b0;
    halt        = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    idex_hold   = 1'b0;
    pipe_done   = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (ex_mul_start) begin
            stop_pc   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
          end else if (id_halt) begin
            halt       = 1'b1;
            ifid_flush = 1'b1;
          end else if (load_use) begin
            stop_pc     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        ST_MUL_WAIT: begin
          if (cnt_q != '0) begin
            stop_pc   = 1'b1;
            ifid_hold = 1'b1;
            idex_hold = 1'b1;
          end
        end
        ST_DRAIN: begin
          halt       = 1'b1;
          ifid_flush = 1'b1;
        end
        ST_HALTED: begin
          halt      = 1'b1;
          pipe_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed vector table, hand sequences
// for multi-cycle behaviour, and randomized traffic against a reference model.
module tb_hazard_unit;

  localparam int unsigned MUL_LAT   = 4;
  localparam int unsigned DRAIN_CYC = 3;
  localparam int unsigned REG_W     = 4;

  typedef struct packed {
    logic       id_valid;
    logic [3:0] id_rs;
    logic [3:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_is_halt;
    logic       ex_valid;
    logic       ex_mem_read;
    logic       ex_mul_start;
    logic [3:0] ex_rd;
    logic       ex_branch_taken;
  } in_t;

  // Bit order: stop_pc, halt, ifid_hold, ifid_flush, idex_bubble, idex_hold, pipe_done
  typedef struct packed {
    logic stop_pc;
    logic halt;
    logic ifid_hold;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_hold;
    logic pipe_done;
  } out_t;

  typedef struct {
    in_t  i;
    out_t e;
  } vec_t;

  localparam out_t O_NONE = 7'b0000000;
  localparam out_t O_MUL  = 7'b1010010;
  localparam out_t O_LU   = 7'b1010100;
  localparam out_t O_BR   = 7'b0001100;
  localparam out_t O_HALT = 7'b0101000;
  localparam out_t O_DONE = 7'b0100001;

  logic             clk;
  logic             rst;
  logic             id_valid, id_uses_rs, id_uses_rt, id_is_halt;
  logic [REG_W-1:0] id_rs, id_rt, ex_rd;
  logic             ex_valid, ex_mem_read, ex_mul_start, ex_branch_taken;
  logic             stop_pc, halt, ifid_hold, ifid_flush, idex_bubble, idex_hold, pipe_done;
  logic [15:0]      stall_cnt;
  out_t             got;

  int checks   = 0;
  int failures = 0;

  // Reference model state: remaining multiply-window cycles, remaining drain
  // cycles, terminal flag and the saturating stall count.
  int m_mul_rem;
  int m_drain_rem;
  int m_stalls;
  bit m_halted;

  vec_t vecs[14];

  hazard_unit #(
    .MUL_LAT   (MUL_LAT),
    .DRAIN_CYC (DRAIN_CYC),
    .REG_W     (REG_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rs      (id_uses_rs),
    .id_uses_rt      (id_uses_rt),
    .id_is_halt      (id_is_halt),
    .ex_valid        (ex_valid),
    .ex_mem_read     (ex_mem_read),
    .ex_mul_start    (ex_mul_start),
    .ex_rd           (ex_rd),
    .ex_branch_taken (ex_branch_taken),
    .stop_pc         (stop_pc),
    .halt            (halt),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_bubble     (idex_bubble),
    .idex_hold       (idex_hold),
    .pipe_done       (pipe_done),
    .stall_cnt       (stall_cnt)
  );

  assign got = {stop_pc, halt, ifid_hold, ifid_flush, idex_bubble, idex_hold, pipe_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(input int v, input int rs, input int rt, input int urs,
                                input int urt, input int ih, input int exv, input int exmr,
                                input int mul, input int rd, input int br);
    in_t s;
    s.id_valid        = 1'(v);
    s.id_rs           = 4'(rs);
    s.id_rt           = 4'(rt);
    s.id_uses_rs      = 1'(urs);
    s.id_uses_rt      = 1'(urt);
    s.id_is_halt      = 1'(ih);
    s.ex_valid        = 1'(exv);
    s.ex_mem_read     = 1'(exmr);
    s.ex_mul_start    = 1'(mul);
    s.ex_rd           = 4'(rd);
    s.ex_branch_taken = 1'(br);
    return s;
  endfunction

  function automatic in_t rand_in();
    in_t s;
    s.id_valid        = 1'($urandom_range(0, 3) != 0);
    s.id_rs           = 4'($urandom_range(0, 3));
    s.id_rt           = 4'($urandom_range(0, 3));
    s.id_uses_rs      = 1'($urandom_range(0, 1));
    s.id_uses_rt      = 1'($urandom_range(0, 1));
    s.id_is_halt      = 1'($urandom_range(0, 29) == 0);
    s.ex_valid        = 1'($urandom_range(0, 3) != 0);
    s.ex_mem_read     = 1'($urandom_range(0, 1));
    s.ex_mul_start    = 1'($urandom_range(0, 7) == 0);
    s.ex_rd           = 4'($urandom_range(0, 3));
    s.ex_branch_taken = 1'($urandom_range(0, 5) == 0);
    return s;
  endfunction

  task automatic drive(input in_t s);
    id_valid        = s.id_valid;
    id_rs           = s.id_rs;
    id_rt           = s.id_rt;
    id_uses_rs      = s.id_uses_rs;
    id_uses_rt      = s.id_uses_rt;
    id_is_halt      = s.id_is_halt;
    ex_valid        = s.ex_valid;
    ex_mem_read     = s.ex_mem_read;
    ex_mul_start    = s.ex_mul_start;
    ex_rd           = s.ex_rd;
    ex_branch_taken = s.ex_branch_taken;
  endtask

  task automatic check_out(input string name, input out_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: outputs got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [15:0] exp);
    checks++;
    if (stall_cnt !== exp) begin
      failures++;
      $display("FAIL %s: stall_cnt got=%h want=%h", name, stall_cnt, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    m_mul_rem   = 0;
    m_drain_rem = 0;
    m_stalls    = 0;
    m_halted    = 1'b0;
  endtask

  function automatic out_t model_out(input in_t s);
    out_t e;
    bit   lu;
    e  = O_NONE;
    lu = s.ex_valid && s.ex_mem_read && (s.ex_rd != 0) && s.id_valid &&
         ((s.id_uses_rs && s.id_rs == s.ex_rd) || (s.id_uses_rt && s.id_rt == s.ex_rd));
    if (m_halted)                         e = O_DONE;
    else if (m_drain_rem > 0)             e = O_HALT;
    else if (m_mul_rem > 1)               e = O_MUL;   // multiply window, still stalling
    else if (m_mul_rem == 1)              e = O_NONE;  // final multiply cycle, no stall
    else if (s.ex_branch_taken)           e = O_BR;
    else if (s.ex_mul_start)              e = O_MUL;
    else if (s.id_valid && s.id_is_halt)  e = O_HALT;
    else if (lu)                          e = O_LU;
    return e;
  endfunction

  task automatic model_advance(input in_t s, input out_t e);
    if (m_halted) begin
    end else if (m_drain_rem > 0) begin
      m_drain_rem--;
      if (m_drain_rem == 0) m_halted = 1'b1;
    end else if (m_mul_rem > 0) begin
      m_mul_rem--;
    end else if (s.ex_branch_taken) begin
    end else if (s.ex_mul_start) begin
      m_mul_rem = MUL_LAT - 1;       // MUL_LAT-2 stall cycles + one release cycle
    end else if (s.id_valid && s.id_is_halt) begin
      m_drain_rem = DRAIN_CYC;
    end
    if (e.stop_pc && m_stalls < 65535) m_stalls++;
  endtask

  // One model-checked cycle; rst_v=0 holds reset for this cycle.
  task automatic step(input in_t s, input logic rst_v);
    out_t e;
    @(negedge clk);
    drive(s);
    rst = rst_v;
    #1;
    if (!rst_v) begin
      model_reset();
      e = O_NONE;
    end else begin
      e = model_out(s);
    end
    check_out("rand_outputs", e);
    check_cnt("rand_stall_cnt", 16'(m_stalls));
    if (rst_v) model_advance(s, e);
  endtask

  // ---------------- directed helpers ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive('0);
  endtask

  task automatic hcheck(input string name, input in_t s, input out_t e);
    @(negedge clk);
    drive(s);
    rst = 1'b1;
    #1;
    check_out(name, e);
  endtask

  initial begin : main
    in_t lu_in, mh_in, h_in;

    rst = 1'b1;
    drive('0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_out("reset_outputs", O_NONE);
    check_cnt("reset_stall_cnt", 16'h0000);

    // ---- single-cycle decisions from RUN ----
    vecs[0]  = '{mk_in(0,0,0,0,0,0,0,0,0,0,0), O_NONE};
    vecs[1]  = '{mk_in(1,5,0,1,0,0,1,1,0,5,0), O_LU};
    vecs[2]  = '{mk_in(1,2,7,0,1,0,1,1,0,7,0), O_LU};
    vecs[3]  = '{mk_in(1,0,0,1,1,0,1,1,0,0,0), O_NONE};
    vecs[4]  = '{mk_in(1,5,0,0,0,0,1,1,0,5,0), O_NONE};
    vecs[5]  = '{mk_in(1,5,0,1,0,0,1,0,0,5,0), O_NONE};
    vecs[6]  = '{mk_in(0,5,0,1,0,0,1,1,0,5,0), O_NONE};
    vecs[7]  = '{mk_in(1,5,0,1,0,0,0,1,0,5,0), O_NONE};
    vecs[8]  = '{mk_in(1,5,0,1,0,1,1,1,0,5,1), O_BR};
    vecs[9]  = '{mk_in(1,5,0,1,0,1,1,1,1,5,0), O_MUL};
    vecs[10] = '{mk_in(1,5,0,1,0,1,1,1,0,5,0), O_HALT};
    vecs[11] = '{mk_in(0,0,0,0,0,1,0,0,0,0,0), O_NONE};
    vecs[12] = '{mk_in(1,3,6,1,0,0,1,1,0,6,0), O_NONE};
    vecs[13] = '{mk_in(1,9,9,1,1,0,1,1,1,9,1), O_BR};
    for (int k = 0; k < 14; k++) begin
      do_reset();
      hcheck($sformatf("vec%0d", k), vecs[k].i, vecs[k].e);
    end

    // ---- load-use: one stall cycle, then the load has moved on ----
    lu_in = mk_in(1,5,0,1,0,0,1,1,0,5,0);
    do_reset();
    hcheck("lu_stall", lu_in, O_LU);
    hcheck("lu_release", mk_in(1,5,0,1,0,0,1,0,0,5,0), O_NONE);
    check_cnt("lu_stall_cnt", 16'd1);

    // ---- zero register: no stall ----
    do_reset();
    hcheck("zero_reg", mk_in(1,0,0,1,0,0,1,1,0,0,0), O_NONE);
    hcheck("zero_reg_next", mk_in(1,0,0,1,0,0,1,1,0,0,0), O_NONE);
    check_cnt("zero_reg_cnt", 16'd0);

    // ---- multiply with HALT held in ID; branch in MUL_WAIT ignored ----
    mh_in = mk_in(1,0,0,0,0,1,1,0,1,0,0);
    h_in  = mk_in(1,0,0,0,0,1,0,0,0,0,0);
    do_reset();
    hcheck("mul_c0", mh_in, O_MUL);
    hcheck("mul_c1_branch_ignored", mk_in(1,0,0,0,0,1,0,0,0,0,1), O_MUL);
    hcheck("mul_c2", h_in, O_MUL);
    hcheck("mul_c3_release", h_in, O_NONE);
    check_cnt("mul_stall_cnt", 16'd3);
    hcheck("mul_c4_halt", h_in, O_HALT);

    // ---- HALT drain and terminal state ----
    do_reset();
    hcheck("halt_c0", h_in, O_HALT);
    for (int c = 1; c <= 3; c++) hcheck($sformatf("halt_drain_c%0d", c), '0, O_HALT);
    for (int c = 4; c < 10; c++) hcheck($sformatf("halted_c%0d", c), rand_in(), O_DONE);

    // ---- async reset mid-MUL_WAIT ----
    do_reset();
    hcheck("mulrst_start", mk_in(0,0,0,0,0,0,1,0,1,0,0), O_MUL);
    hcheck("mulrst_wait", lu_in, O_MUL);
    #1 rst = 1'b0;
    #1;
    check_out("mulrst_async_outputs", O_NONE);
    check_cnt("mulrst_async_cnt", 16'd0);
    hcheck("mulrst_after_release", lu_in, O_LU);

    // ---- saturation of stall_cnt under continuous load-use ----
    do_reset();
    @(negedge clk);
    drive(lu_in);
    rst = 1'b1;
    repeat (65534) @(posedge clk);
    @(negedge clk);
    check_cnt("sat_65534", 16'hFFFE);
    @(negedge clk);
    check_cnt("sat_65535", 16'hFFFF);
    repeat (70000 - 65535) @(posedge clk);
    @(negedge clk);
    check_cnt("sat_70000", 16'hFFFF);

    // ---- randomized traffic against the reference model ----
    step('0, 1'b0);
    for (int n = 0; n < 2000; n++) begin
      in_t s;
      logic r;
      s = rand_in();
      r = ($urandom_range(0, 59) == 0) || (m_halted && ($urandom_range(0, 5) == 0));
      step(s, !r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
